// File: rtl/serial_mag_comparator_if.sv
// Handshake/data bundle for serial_mag_comparator: operands and start in, status and h/e/l result out.
interface serial_mag_comparator_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             h;
  logic             e;
  logic             l;

  modport master (output start, a, b, input busy, done, h, e, l);
  modport slave  (input start, a, b, output busy, done, h, e, l);
endinterface

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first unsigned magnitude comparator, one bit per clock, h/e/l result with done strobe.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mag_comparator_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic             decided, gt_r;
  logic             h_r, e_r, l_r;
  logic             accept, bit_diff, last, bit_gt;

  assign accept   = bus.start && (state != SCAN);
  assign bit_diff = a_r[idx] ^ b_r[idx];
  assign bit_gt   = a_r[idx];
  assign last     = (idx == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = SCAN;
      SCAN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (last || (!decided && bit_diff)) state_nxt = DONE;
`else
        if (last) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = bus.start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      h_r     <= 1'b0;
      e_r     <= 1'b0;
      l_r     <= 1'b0;
    end else if (accept) begin
      a_r     <= bus.a;
      b_r     <= bus.b;
      idx     <= IW'(WIDTH - 1);
      decided <= 1'b0;
      gt_r    <= 1'b0;
      h_r     <= 1'b0;
      e_r     <= 1'b0;
      l_r     <= 1'b0;
    end else if (state == SCAN) begin
      if (!decided && bit_diff) begin
        decided <= 1'b1;
        gt_r    <= bit_gt;
      end
      if (!last) idx <= idx - IW'(1);
      // Result must fold in the bit examined on the exit cycle itself.
      if (state_nxt == DONE) begin
        if (decided) begin
          h_r <= gt_r;
          l_r <= !gt_r;
        end else if (bit_diff) begin
          h_r <= bit_gt;
          l_r <= !bit_gt;
        end else begin
          e_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == SCAN);
  assign bus.done = (state == DONE);
  assign bus.h    = h_r;
  assign bus.e    = e_r;
  assign bus.l    = l_r;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized + directed bench for serial_mag_comparator against a cycle-level behavioural model.
module tb_serial_mag_comparator;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  bit   cmp_en = 1'b0;

  serial_mag_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: remaining scan edges and expected result, derived from plain arithmetic.
  int   m_left = 0;
  logic m_done = 1'b0, m_h = 1'b0, m_e = 1'b0, m_l = 1'b0;
  logic p_h, p_e, p_l;

  function automatic int scan_len(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = WIDTH;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--)
      if (a[i] != b[i]) begin
        n = WIDTH - i;
        break;
      end
`endif
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_h = 0; m_e = 0; m_l = 0;
    end else if (m_left == 0 && bus.start) begin
      p_h = bus.a > bus.b; p_e = bus.a == bus.b; p_l = bus.a < bus.b;
      m_left = scan_len(bus.a, bus.b);
      m_done = 0; m_h = 0; m_e = 0; m_l = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_h = p_h; m_e = p_e; m_l = p_l;
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("hel",  32'({bus.h, bus.e, bus.l}), 32'({m_h, m_e, m_l}));
      if (bus.done) chk("onehot", 32'($countones({bus.h, bus.e, bus.l})), 32'd1);
    end
  end

  // Start on a negedge; count edges (start edge = 1) until done is seen.
  task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int exp_edges, input logic [2:0] exp_hel, input string name);
    int edges;
    bus.start = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk); edges = 1;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk({name, "_edges"}, 32'(edges), 32'(exp_edges));
    chk({name, "_hel"}, 32'({bus.h, bus.e, bus.l}), 32'(exp_hel));
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({bus.busy, bus.done, bus.h, bus.e, bus.l}), 32'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    do_cmp(8'hA5, 8'hA4, 9, 3'b100, "a5_a4");
    do_cmp(8'h3C, 8'h3C, 9, 3'b010, "3c_3c");
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    do_cmp(8'h10, 8'h80, 2, 3'b001, "10_80");
`else
    do_cmp(8'h10, 8'h80, 9, 3'b001, "10_80");
`endif
    do_cmp(8'hFF, 8'h00, WIDTH + 1 - 7 * 0 - ((scan_len(8'hFF, 8'h00) == 1) ? WIDTH - 1 : 0),
           3'b100, "ff_00");

    // Start held high with operands changing every cycle.
    dones = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      case (i % 3)
        0: begin bus.a = 8'hA5; bus.b = 8'hA4; end
        1: begin bus.a = 8'h10; bus.b = 8'h80; end
        default: begin bus.a = 8'h3C; bus.b = 8'h3C; end
      endcase
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    chk("held_start_dones_seen", 32'(dones > 0), 32'd1);
    @(posedge clk); @(negedge clk);

    // Reset at edge 4 of a scan aborts it.
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; bus.start = 1'b0;
    chk("abort_outs", 32'({bus.busy, bus.done, bus.h, bus.e, bus.l}), 32'd0);
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    do_cmp(8'h01, 8'h02, 8, 3'b001, "post_abort");
`else
    do_cmp(8'h01, 8'h02, 9, 3'b001, "post_abort");
`endif

    // Randomized phase: starts, near-equal operands, occasional reset.
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) != 0);
      bus.a = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: bus.b = bus.a;
        1: bus.b = bus.a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: bus.b = WIDTH'($urandom);
      endcase
      rst_n = ($urandom_range(0, 63) != 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
